// File: rtl/xrv_pkg.sv
// Shared definitions for the RV32M execute front-end: funct3 codes, controller
// states and the divide-class decode helper.
package xrv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV_ISSUE,
        ST_DIV_WAIT,
        ST_DRAIN,
        ST_RESP
    } state_t;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

endpackage

// File: rtl/xrv_mul.sv
// MUL_LAT-stage 33x33 signed multiplier with a matching valid pipeline.
// The first stage registers the operands; later stages register the product.
module xrv_mul #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic        valid,
    output logic [63:0] product
);

    logic [32:0] a_q;
    logic [32:0] b_q;
    logic        v_q;
    logic [63:0] prod;

    // Sign-extending to 64 bits keeps the low 64 bits of the signed product exact.
    assign prod = {{31{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= start && !kill;
            if (start) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    generate
        if (MUL_LAT <= 1) begin : g_comb
            assign valid   = v_q;
            assign product = prod;
        end else begin : g_pipe
            logic [63:0] p_q  [MUL_LAT-1];
            logic        pv_q [MUL_LAT-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < MUL_LAT - 1; i++) begin
                        p_q[i]  <= '0;
                        pv_q[i] <= 1'b0;
                    end
                end else begin
                    p_q[0]  <= prod;
                    pv_q[0] <= v_q && !kill;
                    for (int unsigned i = 1; i < MUL_LAT - 1; i++) begin
                        p_q[i]  <= p_q[i-1];
                        pv_q[i] <= pv_q[i-1] && !kill;
                    end
                end
            end

            assign valid   = pv_q[MUL_LAT-2];
            assign product = p_q[MUL_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/xrv_muldiv_ctrl.sv
// RV32M execute front-end: runs multiplies locally, issues divides to xrv_div,
// resolves divide special cases and returns one result per op.
module xrv_muldiv_ctrl
    import xrv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic [2:0]  div_optype,
    output logic        div_valid,
    input  logic [31:0] div_result,
    input  logic        div_result_valid
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  f3_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;

    logic        accept;
    logic        op_div;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_result;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic        mul_valid;
    logic [63:0] mul_product;

    assign accept   = (state == ST_IDLE) && in_valid && !flush;
    assign op_div   = is_div(in_funct3);
    assign div_zero = (in_rs2 == '0);
    assign div_ovf  = !in_funct3[0] && (in_rs1 == 32'h8000_0000) && (in_rs2 == '1);
    assign special  = op_div && (div_zero || div_ovf);

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = in_funct3[1] ? in_rs1 : '1;
        else if (div_ovf)
            special_result = in_funct3[1] ? '0 : 32'h8000_0000;
    end

    assign mul_a = {(in_funct3 != F3_MULHU) && in_rs1[31], in_rs1};
    assign mul_b = {!in_funct3[1] && in_rs2[31], in_rs2};

    xrv_mul #(
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && !op_div),
        .kill    (flush),
        .a       (mul_a),
        .b       (mul_b),
        .valid   (mul_valid),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!op_div)
                        state_next = ST_MUL;
                    else if (special)
                        state_next = ST_RESP;
                    else
                        state_next = ST_DIV_ISSUE;
                end
            end
            ST_MUL: begin
                if (flush)
                    state_next = ST_IDLE;
                else if (mul_valid)
                    state_next = ST_RESP;
            end
            ST_DIV_ISSUE: begin
                state_next = flush ? ST_IDLE : ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                // A flush coinciding with the result has nothing left to drain.
                if (flush)
                    state_next = div_result_valid ? ST_IDLE : ST_DRAIN;
                else if (div_result_valid)
                    state_next = ST_RESP;
            end
            ST_DRAIN: begin
                if (div_result_valid)
                    state_next = ST_IDLE;
            end
            ST_RESP: begin
                if (flush || out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        div_valid = 1'b0;
        unique case (state)
            ST_IDLE:      in_ready  = 1'b1;
            ST_DIV_ISSUE: div_valid = !flush;
            ST_RESP:      out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            out_result <= '0;
        end else begin
            if (accept) begin
                f3_q  <= in_funct3;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                if (special)
                    out_result <= special_result;
            end
            if (state == ST_MUL && mul_valid && !flush)
                out_result <= (f3_q == F3_MUL) ? mul_product[31:0] : mul_product[63:32];
            // Divider remainder sign is sign(a)^sign(b); flip it back to follow the dividend.
            if (state == ST_DIV_WAIT && div_result_valid && !flush)
                out_result <= (f3_q == F3_REM && rs2_q[31]) ? -div_result : div_result;
        end
    end

    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;
    assign div_optype   = f3_q;

endmodule

// File: tb/tb_xrv_muldiv_ctrl.sv
// Directed bench for xrv_muldiv_ctrl with a divider model and an arithmetic
// reference model checked against every response.
module tb_xrv_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [2:0]  div_optype;
    logic        div_valid;
    logic [31:0] div_result;
    logic        div_result_valid;

    xrv_muldiv_ctrl #(
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_funct3        (in_funct3),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_optype       (div_optype),
        .div_valid        (div_valid),
        .div_result       (div_result),
        .div_result_valid (div_result_valid)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          div_pulses = 0;
    int          pulse_cyc = -1;
    int          last_lat = 0;
    logic [31:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Architectural RV32M result.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // What the iterative divider hands back (remainder sign = sign(a)^sign(b)).
    function automatic logic [31:0] div_raw(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, mag;
        if (b == 0) return 32'hFFFF_FFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd4: return 32'(sa / sb);
            3'd5: return a / b;
            3'd6: begin
                mag = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
                return (a[31] ^ b[31]) ? 32'(-mag) : 32'(mag);
            end
            default: return a % b;
        endcase
    endfunction

    initial begin : divider_model
        int          cnt;
        logic [31:0] res;
        cnt = 0;
        res = '0;
        div_result_valid = 1'b0;
        div_result = '0;
        forever begin
            @(negedge clk);
            div_result_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    div_result_valid = 1'b1;
                    div_result = res;
                    pulse_cyc = cyc;
                end
            end
            if (div_valid) begin
                div_pulses++;
                cnt = 33;
                res = div_raw(div_optype, div_dividend, div_divisor);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0)
                        check("spurious out_valid", 32'(out_valid), 32'h0);
                    else begin
                        check("model out_result", out_result, exp_q[0]);
                        if (out_ready && !flush)
                            void'(exp_q.pop_front());
                    end
                end
                if (flush)
                    exp_q.delete();
                else if (in_valid && in_ready)
                    exp_q.push_back(model(in_funct3, in_rs1, in_rs2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, output int acc_cyc, output bit ok);
        int n;
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        ok = in_ready;
        acc_cyc = cyc;
        if (!ok)
            check({name, " accept timeout"}, 32'(in_ready), 32'h1);
        else
            step();
        in_valid = 1'b0;
        in_rs1   = 32'hDEAD_BEEF;
        in_rs2   = 32'h0BAD_F00D;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit,
                          input int exp_pulses, input int hold);
        int acc_cyc, p0, n;
        bit ok;
        p0 = div_pulses;
        accept_op(name, f3, a, b, acc_cyc, ok);
        if (!ok) return;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) begin
            check({name, " response timeout"}, 32'(out_valid), 32'h1);
            return;
        end
        last_lat = cyc - acc_cyc;
        check(name, out_result, lit);
        for (int i = 0; i < hold; i++) begin
            check({name, " hold valid/ready"}, {30'h0, out_valid, in_ready}, 32'h2);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " done valid/ready"}, {30'h0, out_valid, in_ready}, 32'h1);
        check({name, " div_valid pulses"}, 32'(div_pulses - p0), 32'(exp_pulses));
    endtask

    initial begin : driver
        int  acc_cyc, p0, n, seen;
        bit  ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_funct3 = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        check("reset ready/valid/div_valid", {29'h0, in_ready, out_valid, div_valid}, 32'h4);
        check("reset out_result", out_result, 32'h0);
        check("reset div data", div_dividend | div_divisor | 32'(div_optype), 32'h0);
        rst = 1'b0;
        step();

        run_op("MULH 8000_0000^2", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0);
        check("MULH latency", 32'(last_lat), 32'(MUL_LAT + 1));
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 0, 0);
        run_op("MUL", 3'b000, 32'h1234_5678, 32'h9, 32'hA3D7_0A38, 0, 0);

        run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1, 0);
        run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1, 0);
        run_op("REM 7/-2", 3'b110, 32'h7, 32'hFFFF_FFFE, 32'h1, 1, 0);
        run_op("REM -7/-2", 3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 0);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 1, 0);

        run_op("DIV x/0", 3'b100, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0, 0);
        run_op("REMU 5/0", 3'b111, 32'h5, 32'h0, 32'h5, 0, 0);
        run_op("DIV overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run_op("REM overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);

        run_op("MUL backpressure", 3'b000, 32'd3, 32'd5, 32'd15, 0, 10);

        // Flush while the divider is busy: drain its result, then resume.
        p0 = div_pulses;
        accept_op("flush DIV", 3'b101, 32'd100, 32'd7, acc_cyc, ok);
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n = 0;
        seen = 0;
        while (!in_ready && n < 60) begin
            if (out_valid) seen++;
            step();
            n++;
        end
        check("flush no response", 32'(seen), 32'h0);
        check("flush in_ready after drain", 32'(cyc), 32'(pulse_cyc + 1));
        check("flush div_valid pulses", 32'(div_pulses - p0), 32'h1);
        run_op("MUL after flush", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);

        // Reset in DIV_WAIT; the divider's late pulse must be ignored.
        accept_op("rst DIV", 3'b100, 32'hFFFF_FFF9, 32'h2, acc_cyc, ok);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("mid rst ready/valid/div_valid", {29'h0, in_ready, out_valid, div_valid}, 32'h4);
        check("mid rst out_result", out_result, 32'h0);
        check("mid rst div data", div_dividend | div_divisor | 32'(div_optype), 32'h0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("stale div result ignored", 32'(seen), 32'h0);
        run_op("MULHU after rst", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h1, 0, 0);

        repeat (3) step();
        check("scoreboard empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
